// File: rtl/clk_div_ctrl.sv
// Programmable square-wave clock divider with start/stop sequencing.
// Ports: clk_in/reset, en, cfg_valid/cfg_half/cfg_ready/cfg_err, clk_out, tick_rise/tick_fall, running, cur_half.
module clk_div_ctrl #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DEFAULT_HALF = 195
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_half,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 clk_out,
  output logic                 tick_rise,
  output logic                 tick_fall,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] cur_half
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DEF_HALF = DIV_WIDTH'(DEFAULT_HALF);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [DIV_WIDTH-1:0] phalf_q, phalf_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 err_q, err_d;
  logic                 run_q, run_d;

  logic                 accept;
  logic                 boundary;
  logic                 to_idle;

  assign accept   = cfg_valid & ~pend_q;
  // >= rather than == so a count left above a new limit still wraps
  assign boundary = count_q >= (half_q - ONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    half_d  = half_q;
    phalf_d = phalf_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    err_d   = 1'b0;
    to_idle = 1'b0;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        clk_d   = 1'b0;
        if (en) state_d = RUN;
      end
      RUN, STOPPING: begin
        if (boundary) begin
          count_d = '0;
          clk_d   = ~clk_q;
          rise_d  = ~clk_q;
          fall_d  = clk_q;
        end else begin
          count_d = count_q + ONE;
        end
        if (state_q == RUN) begin
          if (!en) begin
            // leave immediately on a low level, else finish the high phase
            if (!clk_d) begin
              state_d = IDLE;
              count_d = '0;
              to_idle = 1'b1;
            end else begin
              state_d = STOPPING;
            end
          end
        end else begin
          if (en) begin
            state_d = RUN;
          end else if (boundary) begin
            state_d = IDLE;
            to_idle = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        clk_d   = 1'b0;
      end
    endcase

    // pending value lands at a period end or on the way to idle
    if (pend_q && (fall_d || to_idle)) begin
      half_d = phalf_q;
      pend_d = 1'b0;
    end

    if (accept) begin
      if (cfg_half == '0) begin
        err_d = 1'b1;
      end else if (state_q == IDLE || to_idle) begin
        half_d = cfg_half;
      end else begin
        phalf_d = cfg_half;
        pend_d  = 1'b1;
      end
    end
  end

  assign run_d = (state_d != IDLE);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      half_q  <= DEF_HALF;
      phalf_q <= DEF_HALF;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      half_q  <= half_d;
      phalf_q <= phalf_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign cfg_err   = err_q;
  assign clk_out   = clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;
  assign running   = run_q;
  assign cur_half  = half_q;

endmodule
